// File: rtl/mips_ctrl.sv
// mips_ctrl -- main instruction decoder for the 5-stage pipelined MIPS core.
//
// Decodes the primary opcode (Op) and, for R-type / SPECIAL2 words, the
// function field (Func) into ALU-stage controls. The decode is purely
// combinational. The only state is a sticky flag. It records that an
// undecodable instruction word was presented.
//
// Ports
//   CLK      in   1  clock, rising edge
//   RESET    in   1  synchronous, active-high; clears Illegal only
//   Op       in   6  instruction [31:26]
//   Func     in   6  instruction [5:0]
//   RegDst   out  1  1 = write Rd, 0 = write Rt
//   ALUOp    out  4  0001 add, 0010 sub, 0100 or-zext16, 1000 lui,
//                    1001 rotrv, 1010 clz, 0000 none (result 0)
//   Alusel   out  1  1 = ALU B operand is the extended immediate
//   clz      out  1  1 = current instruction is CLZ
//   Illegal  out  1  sticky: an undecodable Op/Func was sampled
module mips_ctrl (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] Op,
    input  logic [5:0] Func,
    output logic       RegDst,
    output logic [3:0] ALUOp,
    output logic       Alusel,
    output logic       clz,
    output logic       Illegal
);

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_ROTRV   = 6'b000110;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_NOP     = 6'b000000;
    localparam logic [5:0] FN_CLZ     = 6'b100000;

    localparam logic [3:0] ALU_NONE   = 4'b0000;
    localparam logic [3:0] ALU_ADD    = 4'b0001;
    localparam logic [3:0] ALU_SUB    = 4'b0010;
    localparam logic [3:0] ALU_ORZ    = 4'b0100;
    localparam logic [3:0] ALU_LUI    = 4'b1000;
    localparam logic [3:0] ALU_ROTRV  = 4'b1001;
    localparam logic [3:0] ALU_CLZ    = 4'b1010;

    logic w_illegal;
    logic r_illegal;

    // Undecodable words fall through to the all-zero defaults, so they
    // behave as a nop downstream while raising w_illegal.
    always_comb begin
        RegDst    = 1'b0;
        ALUOp     = ALU_NONE;
        Alusel    = 1'b0;
        clz       = 1'b0;
        w_illegal = 1'b0;
        unique case (Op)
            OP_RTYPE: begin
                unique case (Func)
                    FN_ADDU:  begin RegDst = 1'b1; ALUOp = ALU_ADD;   end
                    FN_SUBU:  begin RegDst = 1'b1; ALUOp = ALU_SUB;   end
                    FN_ROTRV: begin RegDst = 1'b1; ALUOp = ALU_ROTRV; end
                    FN_JR, FN_NOP: ;
                    default:  w_illegal = 1'b1;
                endcase
            end
            OP_SPECIAL2: begin
                if (Func == FN_CLZ) begin
                    RegDst = 1'b1;
                    ALUOp  = ALU_CLZ;
                    clz    = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OP_ORI:       begin ALUOp = ALU_ORZ; Alusel = 1'b1; end
            OP_LW, OP_SW: begin ALUOp = ALU_ADD; Alusel = 1'b1; end
            OP_LUI:       begin ALUOp = ALU_LUI; Alusel = 1'b1; end
            OP_BEQ:       ALUOp = ALU_SUB;
            OP_J, OP_JAL: ;
            default:      w_illegal = 1'b1;
        endcase
    end

    // Reset takes priority over an illegal word on the same edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_illegal <= 1'b0;
        end else if (w_illegal) begin
            r_illegal <= 1'b1;
        end
    end

    assign Illegal = r_illegal;

endmodule

// File: tb/tb_mips_ctrl.sv
// Directed, table-driven bench for mips_ctrl. Each table row gives an
// Op/Func pair, the decode outputs it must produce, and whether it must
// raise Illegal. Hand-written sequences then cover the sticky flag and
// its reset priority.
module tb_mips_ctrl;

    logic       CLK;
    logic       RESET;
    logic [5:0] Op;
    logic [5:0] Func;
    logic       RegDst;
    logic [3:0] ALUOp;
    logic       Alusel;
    logic       clz;
    logic       Illegal;

    int unsigned n_vec;
    int unsigned n_bad;

    mips_ctrl dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .Op      (Op),
        .Func    (Func),
        .RegDst  (RegDst),
        .ALUOp   (ALUOp),
        .Alusel  (Alusel),
        .clz     (clz),
        .Illegal (Illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] func;
        logic       regdst;
        logic [3:0] aluop;
        logic       alusel;
        logic       clz;
        logic       illegal;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_dec(input string name, input logic rd, input logic [3:0] op,
                             input logic as, input logic cz);
        check({name, ".RegDst"}, {7'd0, RegDst}, {7'd0, rd});
        check({name, ".ALUOp"},  {4'd0, ALUOp},  {4'd0, op});
        check({name, ".Alusel"}, {7'd0, Alusel}, {7'd0, as});
        check({name, ".clz"},    {7'd0, clz},    {7'd0, cz});
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        RESET = 1'b0;
        Op    = '0;
        Func  = '0;

        //          name        op         func       rd  aluop    as  clz ill
        tbl.push_back('{"addu",    6'b000000, 6'b100001, 1, 4'b0001, 0, 0, 0});
        tbl.push_back('{"subu",    6'b000000, 6'b100011, 1, 4'b0010, 0, 0, 0});
        tbl.push_back('{"rotrv",   6'b000000, 6'b000110, 1, 4'b1001, 0, 0, 0});
        tbl.push_back('{"jr",      6'b000000, 6'b001000, 0, 4'b0000, 0, 0, 0});
        tbl.push_back('{"nop",     6'b000000, 6'b000000, 0, 4'b0000, 0, 0, 0});
        tbl.push_back('{"clz",     6'b011100, 6'b100000, 1, 4'b1010, 0, 1, 0});
        tbl.push_back('{"ori",     6'b001101, 6'b010101, 0, 4'b0100, 1, 0, 0});
        tbl.push_back('{"lw",      6'b100011, 6'b111111, 0, 4'b0001, 1, 0, 0});
        tbl.push_back('{"sw",      6'b101011, 6'b000000, 0, 4'b0001, 1, 0, 0});
        tbl.push_back('{"lui",     6'b001111, 6'b100001, 0, 4'b1000, 1, 0, 0});
        tbl.push_back('{"beq",     6'b000100, 6'b100011, 0, 4'b0010, 0, 0, 0});
        tbl.push_back('{"j",       6'b000010, 6'b000110, 0, 4'b0000, 0, 0, 0});
        tbl.push_back('{"jal",     6'b000011, 6'b100000, 0, 4'b0000, 0, 0, 0});
        tbl.push_back('{"bad_op",  6'b111111, 6'b100001, 0, 4'b0000, 0, 0, 1});
        tbl.push_back('{"bad_op2", 6'b000001, 6'b000000, 0, 4'b0000, 0, 0, 1});
        tbl.push_back('{"bad_fn",  6'b000000, 6'b100000, 0, 4'b0000, 0, 0, 1});
        tbl.push_back('{"bad_sp2", 6'b011100, 6'b100001, 0, 4'b0000, 0, 0, 1});
        tbl.push_back('{"bad_sp2z",6'b011100, 6'b000000, 0, 4'b0000, 0, 0, 1});

        // Reset state
        do_reset();
        check("reset.Illegal", {7'd0, Illegal}, 8'd0);

        // Each row starts from a cleared flag, so Illegal after one edge
        // reflects only that row's decode.
        foreach (tbl[i]) begin
            do_reset();
            Op   = tbl[i].op;
            Func = tbl[i].func;
            #1;
            check_dec(tbl[i].name, tbl[i].regdst, tbl[i].aluop, tbl[i].alusel, tbl[i].clz);
            @(posedge CLK);
            @(negedge CLK);
            check({tbl[i].name, ".Illegal"}, {7'd0, Illegal}, {7'd0, tbl[i].illegal});
        end

        // Sticky set, then hold through a legal instruction
        do_reset();
        Op = 6'b111111; Func = 6'b000000;
        #1;
        check_dec("seq_bad", 1'b0, 4'b0000, 1'b0, 1'b0);
        check("seq_bad.pre", {7'd0, Illegal}, 8'd0);
        @(posedge CLK);
        @(negedge CLK);
        check("seq_bad.post", {7'd0, Illegal}, 8'd1);
        Op = 6'b000000; Func = 6'b100001;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            check("seq_hold", {7'd0, Illegal}, 8'd1);
        end

        // Decode outputs are independent of RESET
        RESET = 1'b1;
        #1;
        check_dec("reset_addu", 1'b1, 4'b0001, 1'b0, 1'b0);
        check("reset_addu.pre", {7'd0, Illegal}, 8'd1);

        // RESET wins over a simultaneous illegal decode
        Op = 6'b111111; Func = 6'b111111;
        #1;
        check_dec("reset_bad", 1'b0, 4'b0000, 1'b0, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        check("reset_wins", {7'd0, Illegal}, 8'd0);
        RESET = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("reset_release", {7'd0, Illegal}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
